// File: rtl/sliced_add_sequencer_pkg.sv
// rtl/sliced_add_sequencer_pkg.sv - shared constants and FSM encoding for the sliced adder
package sliced_add_sequencer_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_SLICE  = 8;
  localparam int NUM_SLICES = DEF_WIDTH / DEF_SLICE;
  localparam int IDX_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sliced_add_sequencer_if.sv
// rtl/sliced_add_sequencer_if.sv - requester-side handshake and operand/result bundle
interface sliced_add_if #(parameter int WIDTH = 32);

  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             Cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             Cout;
  logic             of;

  modport master (
    output start, sub, a, b, Cin,
    input  busy, done, sum, Cout, of
  );

  modport slave (
    input  start, sub, a, b, Cin,
    output busy, done, sum, Cout, of
  );

endinterface

// File: rtl/sliced_add_sequencer_slice_adder.sv
// rtl/sliced_add_sequencer_slice_adder.sv - combinational ripple-carry adder slice
module slice_adder #(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout
);

  logic c;

  // Ripple the carry bit by bit through the slice
  always_comb begin
    sum = '0;
    c   = cin;
    for (int i = 0; i < SLICE; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/sliced_add_sequencer.sv
// rtl/sliced_add_sequencer.sv - multi-cycle add/subtract over one shared narrow adder slice
module sliced_add_sequencer
  import sliced_add_sequencer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic       clk,
  input  logic       rst,
  sliced_add_if.slave bus
);

  localparam int NUM_SL = WIDTH / SLICE;
  localparam int IX_W   = (NUM_SL > 1) ? $clog2(NUM_SL) : 1;
  localparam logic [IX_W-1:0] LAST_IX = IX_W'(NUM_SL - 1);

  state_t           state;
  logic [IX_W-1:0]  idx;
  logic             carry;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             of_r;
  logic             busy_r;
  logic             done_r;

  logic [SLICE-1:0] a_slice;
  logic [SLICE-1:0] b_slice;
  logic [SLICE-1:0] s_sum;
  logic             s_cout;

  // Select the current slice of the latched operands for the shared adder
  always_comb begin
    a_slice = op_a[idx*SLICE +: SLICE];
    b_slice = op_b[idx*SLICE +: SLICE];
  end

  slice_adder #(.SLICE(SLICE)) u_slice (
    .a    (a_slice),
    .b    (b_slice),
    .cin  (carry),
    .sum  (s_sum),
    .cout (s_cout)
  );

  // Sequencer FSM: latch on start, one slice per cycle, flag results on the last slice
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      carry  <= 1'b0;
      op_a   <= '0;
      op_b   <= '0;
      sum_r  <= '0;
      cout_r <= 1'b0;
      of_r   <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_a   <= bus.a;
            op_b   <= bus.sub ? ~bus.b : bus.b;
            carry  <= bus.sub | bus.Cin;
            idx    <= '0;
            busy_r <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          sum_r[idx*SLICE +: SLICE] <= s_sum;
          carry <= s_cout;
          if (idx == LAST_IX) begin
            // Flags are computed from the final slice so they are valid during DONE
            idx    <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b1;
            cout_r <= s_cout;
            of_r   <= (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                      (s_sum[SLICE-1] != op_a[WIDTH-1]);
            state  <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          done_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.sum  = sum_r;
  assign bus.Cout = cout_r;
  assign bus.of   = of_r;

endmodule
